// File: rtl/ps2_key_pkg.sv
// Shared constants and FSM state type for the PS/2 scan-code to key-event encoder.
package ps2_key_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam int PAUSE_LEN   = 8;
  localparam int PAUSE_CNT_W = 3;
  localparam int PS2_KEY_W   = 65;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_PAUSE  = 2'd2
  } ps2_state_e;

endpackage

// File: rtl/ps2_key_encoder.sv
// Folds PS/2 scan-code bytes (prefixes, break codes, the 8-byte Pause sequence) into one key event word.
// Optional build macro PS2_KEY_TIMEOUT_EN adds an idle timeout that abandons partial sequences.
module ps2_key_encoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 600000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 byte_err,
  output logic [PS2_KEY_W-1:0] ps2_key,
  output logic                 key_strobe,
  output logic                 seq_drop,
  output ps2_state_e           state_dbg
);

  // Input handshake: byte_valid is a one-cycle strobe with no ready; every
  // strobed byte is consumed in the cycle it appears, byte_err qualifies it.

  ps2_state_e                 state, state_d;
  logic [63:0]                acc, acc_d, acc_shift;
  logic [PAUSE_CNT_W-1:0]     pcnt, pcnt_d;
  logic                       complete, drop;
  logic                       timeout_hit;

  assign state_dbg = state;
  assign acc_shift = {acc[55:0], byte_data};

`ifdef PS2_KEY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt;

  assign timeout_hit = (state != ST_IDLE) && (idle_cnt == TMO_LAST);

  // Counts idle cycles spent mid-sequence; any strobed byte restarts it.
  always_ff @(posedge clk_sys) begin
    if (reset || byte_valid || state == ST_IDLE || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    pcnt_d   = pcnt;
    complete = 1'b0;
    drop     = 1'b0;
    if (byte_valid) begin
      if (byte_err) begin
        state_d = ST_IDLE;
        acc_d   = '0;
        pcnt_d  = '0;
        drop    = (state != ST_IDLE);
      end else begin
        unique case (state)
          ST_IDLE, ST_PREFIX: begin
            if (byte_data == SC_EXT || byte_data == SC_BRK) begin
              acc_d   = acc_shift;
              state_d = ST_PREFIX;
            end else if (byte_data == SC_PAUSE) begin
              acc_d   = acc_shift;
              state_d = ST_PAUSE;
              pcnt_d  = PAUSE_CNT_W'(PAUSE_LEN - 1);
            end else begin
              complete = 1'b1;
              acc_d    = '0;
              state_d  = ST_IDLE;
            end
          end
          ST_PAUSE: begin
            // Pause payload bytes are opaque; only the count ends the sequence.
            if (pcnt <= PAUSE_CNT_W'(1)) begin
              complete = 1'b1;
              acc_d    = '0;
              pcnt_d   = '0;
              state_d  = ST_IDLE;
            end else begin
              acc_d  = acc_shift;
              pcnt_d = pcnt - 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            acc_d   = '0;
            pcnt_d  = '0;
          end
        endcase
      end
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      pcnt_d  = '0;
      drop    = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      pcnt       <= '0;
      ps2_key    <= '0;
      key_strobe <= 1'b0;
      seq_drop   <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      pcnt       <= pcnt_d;
      key_strobe <= complete;
      seq_drop   <= drop;
      if (complete) begin
        ps2_key <= {~ps2_key[64], acc_shift};
      end
    end
  end

endmodule
